vreg_file_lanes: RTL and testbench

- Parametrised multi-lane vector register file: NUM_REGS registers, each LANES elements of ELEM_W bits.
- Two combinational read ports, one write port with per-lane write mask, optional write-to-read bypass.
- Register 0 reads as zero.
- Storage carries no reset; after reset, or on request, a sequenced clear engine zeroes one register per cycle.
- Sits in the VMIPS datapath in place of the fixed-width 32x32 vector register file.

---
 rtl/vreg_file_lanes.sv | 113 +++++++++++
 tb/tb_vreg_file_lanes.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_file_lanes.sv
// Multi-lane vector register file: two combinational read ports, one lane-masked write port,
// register 0 hardwired to zero, and a one-register-per-cycle clear engine run after reset.
module vreg_file_lanes #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned ELEM_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(NUM_REGS),
  localparam int unsigned DW      = LANES * ELEM_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] read_reg1,
  input  logic [AW-1:0] read_reg2,
  input  logic [AW-1:0] write_reg,
  input  logic [DW-1:0] write_data,
  input  logic [LANES-1:0] write_mask,
  input  logic          reg_write,
  input  logic          clr_req,
  output logic [DW-1:0] reg_read_data1,
  output logic [DW-1:0] reg_read_data2,
  output logic          busy,
  output logic          clr_done
);

  localparam logic [AW-1:0] LastReg = AW'(NUM_REGS - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_done_q, clr_done_d;
  logic          wr_en;

  logic [LANES-1:0][ELEM_W-1:0] reg_array [NUM_REGS];

  logic [AW-1:0] rd_idx  [2];
  logic [DW-1:0] rd_data [2];

  assign wr_en = (state_q == StIdle) && reg_write && (write_reg != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = AW'(1);
        end
      end
      StClear: begin
        // Terminal compare keeps the counter from ever wrapping back to 0.
        if (cnt_q == LastReg) begin
          state_d    = StIdle;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StClear;
      cnt_q      <= AW'(1);
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
    end
  end

  // Storage has no reset; the sweep defines it.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      reg_array[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (write_mask[l]) reg_array[write_reg][l] <= write_data[l*ELEM_W +: ELEM_W];
      end
    end
  end

  assign rd_idx[0] = read_reg1;
  assign rd_idx[1] = read_reg2;

  // While sweeping every register is logically zero, so reads are forced to zero.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      if ((state_q == StIdle) && (rd_idx[p] != '0)) begin
        for (int l = 0; l < LANES; l++) begin
          if ((BYPASS != 0) && wr_en && write_mask[l] && (rd_idx[p] == write_reg)) begin
            rd_data[p][l*ELEM_W +: ELEM_W] = write_data[l*ELEM_W +: ELEM_W];
          end else begin
            rd_data[p][l*ELEM_W +: ELEM_W] = reg_array[rd_idx[p]][l];
          end
        end
      end
    end
  end

  assign reg_read_data1 = rd_data[0];
  assign reg_read_data2 = rd_data[1];
  assign busy           = (state_q == StClear);
  assign clr_done       = clr_done_q;

endmodule

// File: tb/tb_vreg_file_lanes.sv
// Randomized bench for vreg_file_lanes: a bypass and a non-bypass instance share stimulus and are
// checked every cycle against an array-level model, plus directed sweep/mask/bypass scenarios.
module tb_vreg_file_lanes;

  localparam int unsigned LANES    = 4;
  localparam int unsigned ELEM_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned AW       = $clog2(NUM_REGS);
  localparam int unsigned DW       = LANES * ELEM_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    read_reg1, read_reg2, write_reg;
  logic [DW-1:0]    write_data;
  logic [LANES-1:0] write_mask;
  logic             reg_write, clr_req;
  logic [DW-1:0]    rd1_b, rd2_b, rd1_n, rd2_n;
  logic             busy_b, done_b, busy_n, done_n;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register contents plus remaining sweep cycles.
  logic [DW-1:0] mem [NUM_REGS];
  bit            m_busy, m_done;
  int            m_left;
  bit            obs_busy, obs_done;

  always #5 clk = ~clk;

  vreg_file_lanes #(.LANES(LANES), .ELEM_W(ELEM_W), .NUM_REGS(NUM_REGS), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
    .write_data(write_data), .write_mask(write_mask), .reg_write(reg_write), .clr_req(clr_req),
    .reg_read_data1(rd1_b), .reg_read_data2(rd2_b), .busy(busy_b), .clr_done(done_b)
  );

  vreg_file_lanes #(.LANES(LANES), .ELEM_W(ELEM_W), .NUM_REGS(NUM_REGS), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst(rst), .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
    .write_data(write_data), .write_mask(write_mask), .reg_write(reg_write), .clr_req(clr_req),
    .reg_read_data1(rd1_n), .reg_read_data2(rd2_n), .busy(busy_n), .clr_done(done_n)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*ELEM_W +: ELEM_W] = ELEM_W'($urandom);
    v[0] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_read(input int idx, input bit byp);
    logic [DW-1:0] v;
    if (m_busy || idx == 0) return '0;
    v = mem[idx];
    if (byp && reg_write && int'(write_reg) == idx) begin
      for (int l = 0; l < LANES; l++)
        if (write_mask[l]) v[l*ELEM_W +: ELEM_W] = write_data[l*ELEM_W +: ELEM_W];
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) mem[r] = '0;
    m_busy = 1'b1;
    m_left = NUM_REGS - 1;
    m_done = 1'b0;
  endtask

  task automatic model_step();
    if (m_busy) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_left == 0) m_busy = 1'b0;
    end else begin
      m_done = 1'b0;
      if (reg_write && write_reg != '0) begin
        for (int l = 0; l < LANES; l++)
          if (write_mask[l])
            mem[write_reg][l*ELEM_W +: ELEM_W] = write_data[l*ELEM_W +: ELEM_W];
      end
      // A sweep makes every register logically zero immediately, after any same-edge write.
      if (clr_req) begin
        for (int r = 0; r < NUM_REGS; r++) mem[r] = '0;
        m_busy = 1'b1;
        m_left = NUM_REGS - 1;
      end
    end
  endtask

  task automatic compare_all();
    check("rd1_byp", rd1_b, exp_read(int'(read_reg1), 1'b1));
    check("rd2_byp", rd2_b, exp_read(int'(read_reg2), 1'b1));
    check("rd1_nobyp", rd1_n, exp_read(int'(read_reg1), 1'b0));
    check("rd2_nobyp", rd2_n, exp_read(int'(read_reg2), 1'b0));
    check("busy_byp", DW'(busy_b), DW'(m_busy));
    check("busy_nobyp", DW'(busy_n), DW'(m_busy));
    check("done_byp", DW'(done_b), DW'(m_done));
    check("done_nobyp", DW'(done_n), DW'(m_done));
  endtask

  task automatic tick();
    @(negedge clk);
    obs_busy = busy_b;
    obs_done = done_b;
    compare_all();
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  task automatic write_full(input int r, input logic [DW-1:0] d);
    reg_write  = 1'b1;
    write_reg  = AW'(r);
    write_data = d;
    write_mask = '1;
    tick();
    reg_write  = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_at, done_cnt;
    logic [DW-1:0] e;

    rst = 1'b0; read_reg1 = '0; read_reg2 = '0; write_reg = '0; write_data = '0;
    write_mask = '0; reg_write = 1'b0; clr_req = 1'b0;
    model_reset();
    repeat (3) tick();

    // Post-reset sweep with a write held on reg 5 throughout.
    rst = 1'b1; reg_write = 1'b1; write_reg = AW'(5); write_data = '1; write_mask = '1;
    read_reg1 = AW'(5); read_reg2 = AW'($urandom_range(0, NUM_REGS - 1));
    busy_cnt = 0; done_at = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      if (i == NUM_REGS) reg_write = 1'b0;
      tick();
      if (obs_busy) busy_cnt++;
      if (obs_done) done_at = i;
    end
    check("rst_sweep_len", DW'(busy_cnt), DW'(NUM_REGS - 1));
    check("rst_done_at", DW'(done_at), DW'(NUM_REGS));
    #1;
    check("reg5_dropped", rd1_b, '0);

    for (int r = 1; r < NUM_REGS; r++) write_full(r, rand_data());

    // Masked write.
    e = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    write_full(3, e);
    reg_write = 1'b1; write_reg = AW'(3); write_data = {LANES{32'hAAAAAAAA}}; write_mask = 4'b0101;
    tick();
    reg_write = 1'b0; read_reg1 = AW'(3);
    #1;
    e = {32'h44444444, 32'hAAAAAAAA, 32'h22222222, 32'hAAAAAAAA};
    check("masked_write", rd1_b, e);
    check("masked_write_nb", rd1_n, e);

    // Same-cycle bypass vs. next-cycle visibility.
    write_full(7, {LANES{32'h77777777}});
    reg_write = 1'b1; write_reg = AW'(7); write_data = {LANES{32'h0B0B0B0B}};
    write_mask = 4'b0011; read_reg1 = AW'(7);
    #1;
    e = {32'h77777777, 32'h77777777, 32'h0B0B0B0B, 32'h0B0B0B0B};
    check("bypass_same", rd1_b, e);
    check("nobypass_same", rd1_n, {LANES{32'h77777777}});
    tick();
    reg_write = 1'b0;
    #1;
    check("nobypass_next", rd1_n, e);

    // Register 0 stays zero.
    write_full(0, {LANES{32'hDEADBEEF}});
    read_reg1 = '0; read_reg2 = '0;
    #1;
    check("reg0_p1", rd1_b, '0);
    check("reg0_p2", rd2_b, '0);

    // Randomized traffic with occasional soft clears.
    for (int i = 0; i < 400; i++) begin
      reg_write  = ($urandom_range(0, 3) != 0);
      write_reg  = AW'($urandom_range(0, NUM_REGS - 1));
      write_data = rand_data() ^ DW'($urandom);
      write_mask = LANES'($urandom);
      clr_req    = ($urandom_range(0, 49) == 0);
      read_reg1  = ($urandom_range(0, 2) == 0) ? write_reg : AW'($urandom_range(0, NUM_REGS - 1));
      read_reg2  = AW'($urandom_range(0, NUM_REGS - 1));
      tick();
    end
    reg_write = 1'b0; clr_req = 1'b0;
    for (int i = 0; i < 40 && m_busy; i++) tick();

    // Soft clear with a concurrent write and a re-request mid-sweep.
    for (int r = 1; r < NUM_REGS; r++) write_full(r, rand_data());
    clr_req = 1'b1; reg_write = 1'b1; write_reg = AW'(9); write_data = rand_data();
    write_mask = '1; read_reg1 = AW'(9);
    tick();
    clr_req = 1'b0; reg_write = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      clr_req = (i == 10);
      tick();
      if (obs_busy) busy_cnt++;
      if (obs_done) done_cnt++;
    end
    clr_req = 1'b0;
    check("soft_sweep_len", DW'(busy_cnt), DW'(NUM_REGS - 1));
    check("soft_done_cnt", DW'(done_cnt), DW'(1));
    for (int r = 1; r < NUM_REGS; r++) begin
      read_reg1 = AW'(r); read_reg2 = AW'(NUM_REGS - r);
      #1;
      check("cleared_p1", rd1_b, '0);
      check("cleared_p2", rd2_n, '0);
      tick();
    end

    // Reset mid-sweep restarts the sweep from reg 1.
    for (int r = 1; r < NUM_REGS; r++) write_full(r, rand_data());
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (9) tick();
    rst = 1'b0;
    model_reset();
    tick();
    rst = 1'b1;
    busy_cnt = 0; done_at = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      tick();
      if (obs_busy) busy_cnt++;
      if (obs_done) done_at = i;
    end
    check("rst_mid_len", DW'(busy_cnt), DW'(NUM_REGS - 1));
    check("rst_mid_done_at", DW'(done_at), DW'(NUM_REGS));
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
